afc_freq_comparator: RTL and testbench
======================================

// Module: afc_freq_comparator
// PURPOSE
//  Measurement end of the AFC loop: counts VCO edges over a fixed reference-clock window.
//  Compares the count against a target window and drives the 3-bit comparison code
//  that the AFC search FSM consumes. Watches the FSM state bus and re-measures after every code change.
//  Stops once the FSM reports its finished state.
//  Sits between the VCO divider/synchroniser and afc_fsm_6bit.
// PARAMETERS
//  CNT_W          12   width of edge counter, target and measured count
//  WIN_CYCLES     256  reference cycles per measurement window (>=2)
//  SETTLE_CYCLES  16   reference cycles discarded after a code change (>=1)
//  TOL            2    +/- count tolerance accepted as "freeze"
// PORTS
//  clk          in   1      reference clock
//  rst_n        in   1      async active-low reset
//  en           in   1      measurement enable
//  vco_pulse    in   1      1-cycle pulse per divided VCO edge, already synchronised to clk
//  target_cnt   in   CNT_W  expected edges per window
//  fsm_state    in   6      FSM state bus; bit5 = finished, bits4:0 = cap code
//  comp_out     out  3      {fast,slow,freeze}; 100 fast, 010 slow, 001 freeze, 000 none
//  busy         out  1      high in SETTLE/COUNT/DECIDE
//  meas_cnt     out  CNT_W  last completed window count
// BEHAVIOUR
//  Reset (async, rst_n=0): comp_out=000, busy=0, meas_cnt=0, FSM->IDLE, counters=0.
//  States:
//   IDLE: en=1 and fsm_state[5]=0 -> SETTLE; fsm_state[5]=1 -> DONE.
//   SETTLE: counts SETTLE_CYCLES cycles, then -> COUNT.
//   COUNT: edge counter cleared on entry; runs exactly WIN_CYCLES cycles, then -> DECIDE.
//   DECIDE: 1 cycle; latches meas_cnt; drives comp_out for exactly this cycle.
//    Then -> SETTLE, or -> DONE if fsm_state[5]=1.
//   DONE: comp_out=000, busy=0; leaves only on reset or fsm_state[5] falling (-> IDLE).
//  Decision (registered, one-hot, otherwise 000):
//   cnt < lo -> 010 (slow); cnt > hi -> 100 (fast); else -> 001 (freeze).
//   lo = target_cnt-TOL, clamped at 0; hi = target_cnt+TOL, clamped at 2^CNT_W-1.
//  Timing and counting:
//   Latency: comp_out pulse appears SETTLE_CYCLES+WIN_CYCLES+1 cycles after SETTLE entry.
//   A vco_pulse on every COUNT cycle, including the last, is counted.
//   Pulses outside COUNT are ignored. Edge counter saturates at 2^CNT_W-1; no wrap.
//  Aborts and edge cases:
//   fsm_state change (any bit) during SETTLE/COUNT -> restart SETTLE; no comp_out issued.
//   en=0 in any state except DONE -> IDLE next cycle; comp_out=000, partial count discarded.
//   en falling and DECIDE in the same cycle: the DECIDE pulse is still issued.
//   fsm_state change and DECIDE in the same cycle: pulse is issued, then SETTLE.
//   Exactly one comp_out pulse per completed window; never two consecutive non-zero cycles.
// STRUCTURE
//  afc_pkg: CMP_NONE=3'b000, CMP_FREEZE=3'b001, CMP_SLOW=3'b010, CMP_FAST=3'b100;
//   AFC_STATE_W=6; FIN_BIT=5; comparator state encodings.
//  Sub-module afc_window_counter: cycle timer plus saturating edge counter.
//   Ports: start, len, pulse, done, count.
//  Instantiated once in the top.
//  The top holds the control FSM, fsm_state change detector, clamps and decision register.
// TESTING (bench params: WIN_CYCLES=32, SETTLE_CYCLES=4, TOL=2, target_cnt=20)
//  1 Reset with en=1 and pulses active -> comp_out=000, busy=0, meas_cnt=0 throughout.
//  2 vco_pulse every 2nd cycle -> meas_cnt=16, comp_out=010 for 1 cycle, 37 cycles after SETTLE entry.
//  3 vco_pulse every cycle -> meas_cnt=32, comp_out=100.
//  4 Boundaries: 18 pulses -> 001; 17 -> 010; 22 -> 001; 23 -> 100.
//  5 fsm_state 001100->001101 at COUNT cycle 10 -> no pulse; next pulse 37 cycles after the change.
//  6 fsm_state=111101 after freeze -> DONE, comp_out stays 000, busy=0.
//    rst_n low mid-COUNT -> outputs 0 immediately.

Source files
------------

// File: rtl/afc_freq_comparator_pkg.sv
// Package for the AFC frequency comparator.
// Holds the comparison codes presented to the AFC search FSM, the width and
// layout of the FSM state bus, and the comparator's own state encoding.
package afc_pkg;

    localparam logic [2:0] CMP_NONE   = 3'b000;
    localparam logic [2:0] CMP_FREEZE = 3'b001;
    localparam logic [2:0] CMP_SLOW   = 3'b010;
    localparam logic [2:0] CMP_FAST   = 3'b100;

    localparam int AFC_STATE_W = 6;
    localparam int FIN_BIT     = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COUNT  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } afc_state_e;

endpackage

// File: rtl/afc_freq_comparator_if.sv
// Bus between the AFC search side and the frequency comparator.
//   en          measurement enable
//   vco_pulse   one-cycle pulse per divided VCO edge (already in clk domain)
//   target_cnt  expected edges per window
//   fsm_state   AFC FSM state bus, bit FIN_BIT = finished, low bits = cap code
//   comp_out    {fast,slow,freeze} one-cycle decision code
//   busy        comparator is settling, counting or deciding
//   meas_cnt    count of the last completed window
// master drives the stimulus side, slave is the comparator.
interface afc_freq_comparator_if #(
    parameter int CNT_W = 12
);
    import afc_pkg::*;

    logic                   en;
    logic                   vco_pulse;
    logic [CNT_W-1:0]       target_cnt;
    logic [AFC_STATE_W-1:0] fsm_state;
    logic [2:0]             comp_out;
    logic                   busy;
    logic [CNT_W-1:0]       meas_cnt;

    modport master (
        output en, vco_pulse, target_cnt, fsm_state,
        input  comp_out, busy, meas_cnt
    );

    modport slave (
        input  en, vco_pulse, target_cnt, fsm_state,
        output comp_out, busy, meas_cnt
    );

endinterface

// File: rtl/afc_freq_comparator_window_counter.sv
// Cycle timer plus saturating edge counter.
//   clk, rst_n  clock and async active-low reset
//   start_i     restart: timer and edge count cleared, phase begins next cycle
//   len_i       phase length in cycles
//   pulse_i     edge to count this cycle (caller gates it to the counting phase)
//   done_o      high on the last cycle of the running phase
//   count_o     edge count including this cycle's pulse, saturating
module afc_window_counter #(
    parameter int CNT_W = 12,
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             pulse_i,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o
);

    logic             run_q, run_d;
    logic [LEN_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != '1)) return v + CNT_W'(1);
        return v;
    endfunction

    // count_o already contains the current cycle's pulse so a pulse on the
    // last cycle of the window is visible to the caller on that same cycle.
    assign count_o = sat_inc(cnt_q, pulse_i & run_q);
    assign done_o  = run_q && (tmr_q == (len_i - LEN_W'(1)));

    always_comb begin
        run_d = run_q;
        tmr_d = tmr_q;
        cnt_d = cnt_q;
        if (start_i) begin
            run_d = 1'b1;
            tmr_d = '0;
            cnt_d = '0;
        end else if (run_q) begin
            tmr_d = tmr_q + LEN_W'(1);
            cnt_d = count_o;
            if (done_o) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            tmr_q <= '0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            tmr_q <= tmr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/afc_freq_comparator.sv
// AFC frequency comparator: counts VCO edges over a fixed reference window,
// compares against target_cnt +/- TOL and issues a one-cycle comparison code
// to the AFC search FSM. Re-measures whenever the FSM state bus changes and
// parks once the FSM reports finished.
//   clk, rst_n  reference clock, async active-low reset
//   bus         slave side of afc_freq_comparator_if (en, vco_pulse,
//               target_cnt, fsm_state in; comp_out, busy, meas_cnt out)
module afc_freq_comparator
    import afc_pkg::*;
#(
    parameter int CNT_W         = 12,
    parameter int WIN_CYCLES    = 256,
    parameter int SETTLE_CYCLES = 16,
    parameter int TOL           = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    afc_freq_comparator_if.slave bus
);

    localparam int LEN_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int LEN_W   = $clog2(LEN_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);

    function automatic logic [CNT_W-1:0] clamp_lo(input logic [CNT_W-1:0] t);
        if (t < TOL_C) return '0;
        return t - TOL_C;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_hi(input logic [CNT_W-1:0] t);
        if (t > (CNT_MAX - TOL_C)) return CNT_MAX;
        return t + TOL_C;
    endfunction

    function automatic logic [2:0] decide(input logic [CNT_W-1:0] cnt,
                                          input logic [CNT_W-1:0] t);
        if (cnt < clamp_lo(t)) return CMP_SLOW;
        if (cnt > clamp_hi(t)) return CMP_FAST;
        return CMP_FREEZE;
    endfunction

    afc_state_e             state_q, state_d;
    logic [AFC_STATE_W-1:0] fsm_prev_q;
    logic [2:0]             comp_q, comp_d;
    logic [CNT_W-1:0]       meas_q, meas_d;

    logic             win_start;
    logic [LEN_W-1:0] win_len;
    logic             win_done;
    logic [CNT_W-1:0] win_count;

    logic fsm_chg;
    logic fin;

    assign fsm_chg = (bus.fsm_state != fsm_prev_q);
    assign fin     = bus.fsm_state[FIN_BIT];
    assign win_len = (state_q == ST_COUNT) ? LEN_W'(WIN_CYCLES) : LEN_W'(SETTLE_CYCLES);

    afc_window_counter #(
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) u_win (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (win_start),
        .len_i   (win_len),
        .pulse_i (bus.vco_pulse && (state_q == ST_COUNT)),
        .done_o  (win_done),
        .count_o (win_count)
    );

    // The decision is registered on the edge into DECIDE, so comp_out is
    // non-zero exactly while the FSM sits in DECIDE and nowhere else.
    always_comb begin
        state_d   = state_q;
        win_start = 1'b0;
        comp_d    = CMP_NONE;
        meas_d    = meas_q;
        case (state_q)
            ST_IDLE: begin
                if (fin) begin
                    state_d = ST_DONE;
                end else if (bus.en) begin
                    state_d   = ST_SETTLE;
                    win_start = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (fsm_chg || win_done) begin
                    state_d   = fsm_chg ? ST_SETTLE : ST_COUNT;
                    win_start = 1'b1;
                end
            end
            ST_COUNT: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (fsm_chg) begin
                    state_d   = ST_SETTLE;
                    win_start = 1'b1;
                end else if (win_done) begin
                    state_d = ST_DECIDE;
                    comp_d  = decide(win_count, bus.target_cnt);
                    meas_d  = win_count;
                end
            end
            ST_DECIDE: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (fin) begin
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_SETTLE;
                    win_start = 1'b1;
                end
            end
            ST_DONE: begin
                if (!fin) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fsm_prev_q <= '0;
            comp_q     <= CMP_NONE;
            meas_q     <= '0;
        end else begin
            state_q    <= state_d;
            fsm_prev_q <= bus.fsm_state;
            comp_q     <= comp_d;
            meas_q     <= meas_d;
        end
    end

    assign bus.comp_out = comp_q;
    assign bus.busy     = (state_q == ST_SETTLE) || (state_q == ST_COUNT) || (state_q == ST_DECIDE);
    assign bus.meas_cnt = meas_q;

endmodule

// File: tb/tb_afc_freq_comparator.sv
module tb_afc_freq_comparator;
    import afc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    afc_freq_comparator_if #(.CNT_W(12)) bus ();

    afc_freq_comparator #(
        .CNT_W         (12),
        .WIN_CYCLES    (32),
        .SETTLE_CYCLES (4),
        .TOL           (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Starts a measurement from IDLE (en low). Index 0 is the trigger cycle;
    // SETTLE occupies 1..4, COUNT 5..36, DECIDE 37. vco_pulse is held high
    // outside COUNT so stray pulses would corrupt the count if not ignored.
    // mode 0: pulses on the first npulse COUNT cycles; mode 1: every 2nd cycle.
    task automatic measure(input string tag, input int mode, input int npulse,
                           input int drop_idx, input logic [2:0] exp_code,
                           input logic [11:0] exp_cnt);
        int first_nz;
        int nz;
        int k;
        first_nz = -1;
        nz       = 0;
        @(negedge clk);
        bus.en        = 1'b1;
        bus.vco_pulse = 1'b1;
        for (int idx = 1; idx <= 39; idx++) begin
            @(negedge clk);
            if (bus.comp_out != CMP_NONE) begin
                nz++;
                if (first_nz < 0) first_nz = idx;
            end
            if (idx == 37) begin
                chk_eq($sformatf("%s.code", tag), 32'(bus.comp_out), 32'(exp_code));
                chk_eq($sformatf("%s.meas", tag), 32'(bus.meas_cnt), 32'(exp_cnt));
                chk_eq($sformatf("%s.busy_decide", tag), 32'(bus.busy), 32'd1);
            end
            if (idx == 39) chk_eq($sformatf("%s.busy_after", tag), 32'(bus.busy), 32'd0);
            k = idx - 5;
            if (idx >= 5 && idx <= 36)
                bus.vco_pulse = (mode == 1) ? (k % 2 == 0) : (k < npulse);
            else
                bus.vco_pulse = 1'b1;
            if (idx >= drop_idx) bus.en = 1'b0;
        end
        bus.vco_pulse = 1'b0;
        chk_eq($sformatf("%s.latency", tag), 32'(first_nz), 32'd37);
        chk_eq($sformatf("%s.npulse", tag), 32'(nz), 32'd1);
    endtask

    initial begin
        int first_nz;
        int nz;
        int busy_seen;
        n_chk          = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.en         = 1'b1;
        bus.vco_pulse  = 1'b0;
        bus.target_cnt = 12'd20;
        bus.fsm_state  = 6'b001100;

        // Reset held with enable and pulses active
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_eq("rst.comp", 32'(bus.comp_out), 32'd0);
            chk_eq("rst.busy", 32'(bus.busy), 32'd0);
            chk_eq("rst.meas", 32'(bus.meas_cnt), 32'd0);
            bus.vco_pulse = ~bus.vco_pulse;
        end
        bus.en        = 1'b0;
        bus.vco_pulse = 1'b0;
        rst_n         = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("idle.busy", 32'(bus.busy), 32'd0);

        measure("half",  1, 0,  38, CMP_SLOW,   12'd16);
        measure("full",  0, 32, 38, CMP_FAST,   12'd32);
        measure("b18",   0, 18, 38, CMP_FREEZE, 12'd18);
        measure("b17",   0, 17, 38, CMP_SLOW,   12'd17);
        measure("b22",   0, 22, 37, CMP_FREEZE, 12'd22);
        measure("b23",   0, 23, 38, CMP_FAST,   12'd23);

        // Cap code change at COUNT cycle 10 restarts SETTLE
        first_nz = -1;
        nz       = 0;
        @(negedge clk);
        bus.en        = 1'b1;
        bus.vco_pulse = 1'b1;
        for (int idx = 1; idx <= 54; idx++) begin
            @(negedge clk);
            if (bus.comp_out != CMP_NONE) begin
                nz++;
                if (first_nz < 0) first_nz = idx;
            end
            if (idx == 40) chk_eq("abort.meas_kept", 32'(bus.meas_cnt), 32'd23);
            if (idx == 52) begin
                chk_eq("abort.code", 32'(bus.comp_out), 32'(CMP_FAST));
                chk_eq("abort.meas", 32'(bus.meas_cnt), 32'd32);
            end
            if (idx == 15) bus.fsm_state = 6'b001101;
            if (idx == 54) bus.en = 1'b0;
        end
        chk_eq("abort.latency", 32'(first_nz), 32'd52);
        chk_eq("abort.npulse", 32'(nz), 32'd1);
        bus.vco_pulse = 1'b0;
        @(negedge clk);
        chk_eq("abort.idle", 32'(bus.busy), 32'd0);

        measure("freeze", 0, 20, 38, CMP_FREEZE, 12'd20);

        // Finished flag parks the comparator
        @(negedge clk);
        bus.fsm_state = 6'b111101;
        bus.en        = 1'b1;
        bus.vco_pulse = 1'b1;
        nz        = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.comp_out != CMP_NONE) nz++;
            if (bus.busy) busy_seen++;
        end
        chk_eq("done.comp", 32'(nz), 32'd0);
        chk_eq("done.busy", 32'(busy_seen), 32'd0);

        // Finished flag falling resumes measuring
        bus.fsm_state = 6'b011101;
        @(negedge clk);
        chk_eq("resume.idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk_eq("resume.busy", 32'(bus.busy), 32'd1);
        repeat (14) @(negedge clk);
        chk_eq("midcount.busy", 32'(bus.busy), 32'd1);
        chk_eq("midcount.meas", 32'(bus.meas_cnt), 32'd20);

        // Asynchronous reset mid-COUNT
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst.comp", 32'(bus.comp_out), 32'd0);
        chk_eq("arst.busy", 32'(bus.busy), 32'd0);
        chk_eq("arst.meas", 32'(bus.meas_cnt), 32'd0);
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("post_rst.busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
